ic_rgbtoycbcr_chan_mux_pipe: RTL and testbench

- Parametrised, registered successor to the one-hot 3:1 channel selector in the RGB-to-YCbCr stage.
- Selects one of N W-bit channel words per accepted beat, either by external one-hot select or by an internal round-robin sequencer.
- Results pass through a 2-entry output buffer with valid/ready handshake, so the downstream colour-conversion pipeline can stall without losing data.
- Sits between the per-channel block buffers and the YCbCr arithmetic.

---
 rtl/ic_rgbtoycbcr_chan_mux_pipe.sv | 143 ++++++++++++++
 tb/tb_ic_rgbtoycbcr_chan_mux_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ic_rgbtoycbcr_chan_mux_pipe.sv
// N-way channel word selector (manual one-hot or auto round-robin) feeding a
// 2-entry valid/ready output buffer ahead of the YCbCr arithmetic.
module ic_rgbtoycbcr_chan_mux_pipe #(
    parameter int unsigned N_CH  = 3,
    parameter int unsigned W     = 64,
    parameter int unsigned BEATS = 8
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         mode,
    input  logic [N_CH-1:0]                              sel,
    input  logic [N_CH*W-1:0]                            in_data,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    output logic [W-1:0]                                 out_data,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]   out_chan,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic                                         sel_err,
    input  logic                                         err_clr
);

    localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CW-1:0] ptr;
    logic [BW-1:0] beat_cnt;
    logic          mode_q;
    logic [W-1:0]  skid_data;
    logic [CW-1:0] skid_chan;
    logic          skid_valid;

    logic          accept_c;
    logic          drain_c;
    logic          mode_chg_c;
    logic          onehot_c;
    logic [CW-1:0] cur_ptr_c;
    logic [W-1:0]  cap_data_c;
    logic [CW-1:0] cap_chan_c;
    logic [1:0]    occ_c;
    logic [1:0]    occ_next_c;

    assign accept_c   = in_valid && in_ready;
    assign drain_c    = out_valid && out_ready;
    assign mode_chg_c = (mode != mode_q);
    assign cur_ptr_c  = mode_chg_c ? '0 : ptr;
    assign onehot_c   = (sel != '0) && ((sel & (sel - N_CH'(1))) == '0);

    // Word/channel captured for the current beat; zero fill on a bad manual select.
    always_comb begin
        cap_data_c = '0;
        cap_chan_c = '0;
        if (mode) begin
            cap_chan_c = cur_ptr_c;
            for (int k = 0; k < N_CH; k++) begin
                if (CW'(k) == cur_ptr_c) cap_data_c = in_data[k*W +: W];
            end
        end else if (onehot_c) begin
            for (int k = 0; k < N_CH; k++) begin
                if (sel[k]) begin
                    cap_data_c = in_data[k*W +: W];
                    cap_chan_c = CW'(k);
                end
            end
        end
    end

    always_comb begin
        occ_c      = 2'({1'b0, out_valid}) + 2'({1'b0, skid_valid});
        occ_next_c = 2'(occ_c + 2'({1'b0, accept_c}) - 2'({1'b0, drain_c}));
    end

    // Round-robin sequencer; a mode change restarts it from channel 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr      <= '0;
            beat_cnt <= '0;
            mode_q   <= 1'b0;
        end else begin
            mode_q <= mode;
            if (mode_chg_c) begin
                ptr      <= '0;
                beat_cnt <= '0;
            end else if (accept_c && mode) begin
                if (beat_cnt == BW'(BEATS - 1)) begin
                    beat_cnt <= '0;
                    ptr      <= (ptr == CW'(N_CH - 1)) ? '0 : ptr + CW'(1);
                end else begin
                    beat_cnt <= beat_cnt + BW'(1);
                end
            end
        end
    end

    // Head entry is the output register; skid entry holds the second word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data   <= '0;
            out_chan   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_chan  <= '0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            if (!out_valid || drain_c) begin
                if (skid_valid) begin
                    out_data   <= skid_data;
                    out_chan   <= skid_chan;
                    out_valid  <= 1'b1;
                    skid_valid <= accept_c;
                    if (accept_c) begin
                        skid_data <= cap_data_c;
                        skid_chan <= cap_chan_c;
                    end
                end else begin
                    out_valid <= accept_c;
                    if (accept_c) begin
                        out_data <= cap_data_c;
                        out_chan <= cap_chan_c;
                    end
                end
            end else if (accept_c) begin
                skid_data  <= cap_data_c;
                skid_chan  <= cap_chan_c;
                skid_valid <= 1'b1;
            end
            in_ready <= (occ_next_c < 2'd2);
        end
    end

    // Sticky select error; a new error wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err <= 1'b0;
        end else if (accept_c && !mode && !onehot_c) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ic_rgbtoycbcr_chan_mux_pipe.sv
// Directed bench for ic_rgbtoycbcr_chan_mux_pipe with hand-computed expectations.
module tb_ic_rgbtoycbcr_chan_mux_pipe;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         mode;
    logic [2:0]   sel;
    logic [191:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  out_data;
    logic [1:0]   out_chan;
    logic         out_valid;
    logic         out_ready;
    logic         sel_err;
    logic         err_clr;

    int n_cmp = 0;
    int n_err = 0;

    ic_rgbtoycbcr_chan_mux_pipe #(.N_CH(3), .W(64), .BEATS(8)) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready), .sel_err(sel_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [63:0] c0, input logic [63:0] c1, input logic [63:0] c2);
        in_data = {c2, c1, c0};
    endtask

    initial begin
        reset_n = 1'b0; mode = 1'b0; sel = 3'b000; in_valid = 1'b0;
        out_ready = 1'b1; err_clr = 1'b0;
        set_data(64'h11, 64'h22, 64'h33);
        step(); step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  out_data, 64'd0);
        chk("rst_out_chan",  64'(out_chan), 64'd0);
        chk("rst_sel_err",   64'(sel_err), 64'd0);
        chk("rst_in_ready",  64'(in_ready), 64'd1);
        reset_n = 1'b1;
        step();

        // Manual one-hot select
        sel = 3'b010; in_valid = 1'b1;
        step();
        chk("man_valid", 64'(out_valid), 64'd1);
        chk("man_data",  out_data, 64'h22);
        chk("man_chan",  64'(out_chan), 64'd1);
        chk("man_err",   64'(sel_err), 64'd0);
        in_valid = 1'b0;
        step();
        chk("man_drained", 64'(out_valid), 64'd0);

        // Manual select errors
        sel = 3'b011; in_valid = 1'b1;
        step();
        chk("err1_data", out_data, 64'd0);
        chk("err1_chan", 64'(out_chan), 64'd0);
        chk("err1_flag", 64'(sel_err), 64'd1);
        sel = 3'b100;
        step();
        chk("good_data", out_data, 64'h33);
        chk("good_chan", 64'(out_chan), 64'd2);
        sel = 3'b000;
        step();
        chk("err0_data",  out_data, 64'd0);
        chk("err0_chan",  64'(out_chan), 64'd0);
        chk("err0_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        step();
        chk("err_sticky", 64'(sel_err), 64'd1);
        err_clr = 1'b1;
        step();
        chk("err_clr", 64'(sel_err), 64'd0);
        sel = 3'b101; in_valid = 1'b1;
        step();
        chk("err_set_wins", 64'(sel_err), 64'd1);
        err_clr = 1'b0; in_valid = 1'b0;
        step();

        // Auto round-robin: 8 beats per channel, wrap after channel 2
        mode = 1'b1;
        step();
        in_valid = 1'b1;
        for (int i = 0; i < 25; i++) begin
            logic [1:0] ec;
            ec = 2'((i / 8) % 3);
            step();
            chk($sformatf("auto_chan%0d", i), 64'(out_chan), 64'(ec));
            chk($sformatf("auto_data%0d", i), out_data,
                (ec == 2'd0) ? 64'h11 : (ec == 2'd1) ? 64'h22 : 64'h33);
        end
        in_valid = 1'b0;
        step();

        // Backpressure: pointer 0, counter 1 on entry
        out_ready = 1'b0; in_valid = 1'b1;
        set_data(64'hAA, 64'h22, 64'h33);
        step();
        chk("bp1_data",  out_data, 64'hAA);
        chk("bp1_ready", 64'(in_ready), 64'd1);
        set_data(64'hBB, 64'h22, 64'h33);
        step();
        chk("bp2_ready", 64'(in_ready), 64'd0);
        chk("bp2_data",  out_data, 64'hAA);
        set_data(64'hCC, 64'h22, 64'h33);
        step();
        chk("bp3_data",  out_data, 64'hAA);
        chk("bp3_valid", 64'(out_valid), 64'd1);
        step();
        chk("bp4_ready", 64'(in_ready), 64'd0);
        chk("bp4_data",  out_data, 64'hAA);
        out_ready = 1'b1;
        step();
        chk("drain1_data",  out_data, 64'hBB);
        chk("drain1_ready", 64'(in_ready), 64'd1);
        step();
        chk("drain2_data", out_data, 64'hCC);
        chk("drain2_chan", 64'(out_chan), 64'd0);
        in_valid = 1'b0;
        set_data(64'h11, 64'h22, 64'h33);
        step();
        chk("drain_empty", 64'(out_valid), 64'd0);
        // Counter is at 4: four more channel-0 beats, then channel 1
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_cnt_chan%0d", i), 64'(out_chan), (i < 4) ? 64'd0 : 64'd1);
        end
        // Bring counter to 5 on channel 1
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("pre_sw_chan%0d", i), 64'(out_chan), 64'd1);
        end

        // Mode switch restarts the sequencer
        in_valid = 1'b0; mode = 1'b0;
        step();
        mode = 1'b1;
        step();
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("sw_chan%0d", i), 64'(out_chan), (i < 8) ? 64'd0 : 64'd1);
        end
        in_valid = 1'b0;
        step();

        // Reset with a full buffer and the error flag set
        mode = 1'b0; out_ready = 1'b0;
        step();
        sel = 3'b011; in_valid = 1'b1;
        step();
        sel = 3'b001;
        step();
        chk("full_ready", 64'(in_ready), 64'd0);
        chk("full_valid", 64'(out_valid), 64'd1);
        chk("full_err",   64'(sel_err), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_data",  out_data, 64'd0);
        chk("mrst_err",   64'(sel_err), 64'd0);
        in_valid = 1'b0; out_ready = 1'b1; mode = 1'b1;
        step();
        reset_n = 1'b1;
        step();
        chk("mrst_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        step();
        chk("mrst_chan",  64'(out_chan), 64'd0);
        chk("mrst_data2", out_data, 64'h11);
        in_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
